// File: rtl/uart_tx_arbiter_if.sv
// Requester / transmitter side signals of the UART TX arbiter.
// master = arbiter, slave = requesters plus transmitter stub.
interface uart_tx_arbiter_if #(
  parameter int CHANNELS  = 4,
  parameter int CH_BITS   = 2,
  parameter int DATA_BITS = 8
);
  logic [CHANNELS-1:0]           chan_enable;
  logic [CHANNELS-1:0]           req;
  logic [CHANNELS*DATA_BITS-1:0] req_data;
  logic [CHANNELS-1:0]           ack;
  logic                          tx_start;
  logic [DATA_BITS-1:0]          tx_data;
  logic                          tx_done_tick;
  logic [CH_BITS-1:0]            grant_ch;
  logic                          busy;

  modport master (
    input  chan_enable, req, req_data, tx_done_tick,
    output ack, tx_start, tx_data, grant_ch, busy
  );

  modport slave (
    output chan_enable, req, req_data, tx_done_tick,
    input  ack, tx_start, tx_data, grant_ch, busy
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among CHANNELS byte
// requesters, optionally prefixing each byte with a channel tag byte.
module uart_tx_arbiter #(
  parameter int                   CHANNELS   = 4,
  parameter int                   CH_BITS    = 2,
  parameter int                   DATA_BITS  = 8,
  parameter bit                   TAG_ENABLE = 1'b1,
  parameter logic [DATA_BITS-1:0] TAG_BASE   = DATA_BITS'(8'hF0)
) (
  input  logic              clk,
  input  logic              reset,
  uart_tx_arbiter_if.master bus
);
  typedef enum logic [2:0] {
    IDLE, TAG_START, TAG_WAIT, DATA_START, DATA_WAIT
  } state_t;

  state_t                              state, state_nxt;
  logic [CH_BITS-1:0]                  rr, sel, grant_q;
  logic                                found;
  logic [CH_BITS:0]                    idx;
  logic [CHANNELS-1:0]                 eff, ack_q;
  logic [CHANNELS-1:0][DATA_BITS-1:0]  lane_data;
  logic [DATA_BITS-1:0]                byte_q, tx_data_q;
  logic                                grant_now;

  assign eff = bus.req & bus.chan_enable;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    assign lane_data[i] = bus.req_data[i*DATA_BITS +: DATA_BITS];
  end

  // Search upward from rr+1, wrapping modulo CHANNELS (not 2^CH_BITS).
  always_comb begin
    sel   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= CHANNELS; k++) begin
      idx = {1'b0, rr} + (CH_BITS+1)'(k);
      if (idx >= (CH_BITS+1)'(CHANNELS)) idx = idx - (CH_BITS+1)'(CHANNELS);
      if (!found && eff[idx[CH_BITS-1:0]]) begin
        sel   = idx[CH_BITS-1:0];
        found = 1'b1;
      end
    end
  end

  assign grant_now = (state == IDLE) && found;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       if (found) state_nxt = TAG_ENABLE ? TAG_START : DATA_START;
      TAG_START:  state_nxt = TAG_WAIT;
      TAG_WAIT:   if (bus.tx_done_tick) state_nxt = DATA_START;
      DATA_START: state_nxt = DATA_WAIT;
      DATA_WAIT:  if (bus.tx_done_tick) state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.tx_start = (state == TAG_START) || (state == DATA_START);
    bus.busy     = (state != IDLE);
  end

  // Datapath: the byte is latched at grant so the requester may move on.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr        <= CH_BITS'(CHANNELS-1);
      grant_q   <= '0;
      byte_q    <= '0;
      tx_data_q <= '0;
      ack_q     <= '0;
    end else begin
      ack_q <= '0;
      if (grant_now) begin
        rr        <= sel;
        grant_q   <= sel;
        byte_q    <= lane_data[sel];
        ack_q     <= CHANNELS'(1) << sel;
        tx_data_q <= TAG_ENABLE ? (TAG_BASE + DATA_BITS'(sel)) : lane_data[sel];
      end else if (state == TAG_WAIT && bus.tx_done_tick) begin
        tx_data_q <= byte_q;
      end
    end
  end

  assign bus.ack      = ack_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.grant_ch = grant_q;
endmodule
